// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, fetch-state encoding and queue entry type
// for the instruction fetch controller.
package imem_pkg;

  localparam int          IMEM_WORDS = 128;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          XLEN       = 32;
  localparam logic [5:0]  OPC_J      = 6'b000010;

  localparam logic [1:0]  FETCH = 2'd0;
  localparam logic [1:0]  FAULT = 2'd1;
  localparam logic [1:0]  HALT  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {pc, instr} fetch records.
// Flush wins over push and pop; push is accepted when full only with a pop.
import imem_pkg::*;

module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  logic      i_pop,
  input  logic      i_flush,
  input  fq_entry_t i_data,
  output logic      o_full,
  output logic      o_empty,
  output fq_entry_t o_head
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_pop;
  logic          w_push;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + AW'(1);
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      if (w_push & ~w_pop)
        r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop & ~w_push)
        r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_push & ~i_flush) begin
      r_mem[r_wr] <= i_data;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch PC, FETCH/FAULT/HALT FSM and fetch queue feeding decode.
// Self-loop halt detection is built only with IMEM_FETCH_HALT_DETECT_EN defined.
import imem_pkg::*;

module imem_fetch_ctrl #(
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = imem_pkg::IMEM_WORDS,
  parameter logic [31:0] RESET_PC   = imem_pkg::RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPC,
  output logic        Fault,
  output logic        Halted
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  logic [31:0] r_pc;
  logic [1:0]  r_state;
  fq_entry_t   r_hold;

  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_try;
  logic        w_in_range;
  logic        w_push;
  logic        w_self_loop;
  logic [31:0] w_pc_inc;
  logic [31:0] w_redir_pc;
  fq_entry_t   w_head;
  fq_entry_t   w_wdata;
  fq_entry_t   w_out;

  assign w_pc_inc   = r_pc + 32'd4;
  assign w_redir_pc = RedirectPC & ~32'd3;
  assign w_pop      = ~w_empty & InstrReady;
  assign w_try      = (r_state == FETCH) & Enable & ~RedirectValid
                    & (~w_full | w_pop);
  assign w_in_range = (r_pc < PC_LIMIT);
  assign w_push     = w_try & w_in_range;
  assign w_wdata    = '{pc: r_pc, instr: ImemInstruction};

`ifdef IMEM_FETCH_HALT_DETECT_EN
  logic [31:0] w_jtarget;
  assign w_jtarget   = {w_pc_inc[31:28], ImemInstruction[25:0], 2'b00};
  assign w_self_loop = (ImemInstruction[31:26] == OPC_J)
                     & (w_jtarget == r_pc);
  assign Halted      = (r_state == HALT);
`else
  assign w_self_loop = 1'b0;
  assign Halted      = 1'b0;
`endif

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (RedirectValid),
    .i_data  (w_wdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // A failed range check replaces the push with the move to FAULT.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc    <= RESET_PC;
      r_state <= FETCH;
    end else if (RedirectValid) begin
      r_pc    <= w_redir_pc;
      r_state <= FETCH;
    end else if (w_push) begin
      r_pc <= w_pc_inc;
      if (w_self_loop)
        r_state <= HALT;
    end else if (w_try) begin
      r_state <= FAULT;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_hold <= '0;
    else if (~w_empty)
      r_hold <= w_head;
  end

  assign w_out       = w_empty ? r_hold : w_head;
  assign ImemAddress = r_pc;
  assign InstrValid  = ~w_empty;
  assign InstrOut    = w_out.instr;
  assign InstrPC     = w_out.pc;
  assign Fault       = (r_state == FAULT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_imem_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        InstrReady = 1'b0;
  logic        RedirectValid = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic [31:0] ImemAddress;
  logic [31:0] ImemInstruction;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        Fault;
  logic        Halted;

  logic [31:0] mem [128];
  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  assign ImemInstruction = mem[ImemAddress[8:2]];

  imem_fetch_ctrl dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Enable          (Enable),
    .ImemAddress     (ImemAddress),
    .ImemInstruction (ImemInstruction),
    .InstrValid      (InstrValid),
    .InstrReady      (InstrReady),
    .InstrOut        (InstrOut),
    .InstrPC         (InstrPC),
    .RedirectValid   (RedirectValid),
    .RedirectPC      (RedirectPC),
    .Fault           (Fault),
    .Halted          (Halted)
  );

  typedef struct {
    bit          rst;
    bit          en;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] addr;
    bit          flt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  vec_t tbl[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Expected instruction equals the PC while memory holds word i = i*4.
  function automatic vec_t mk(bit rst, bit en, bit rdy, bit rv,
                              logic [31:0] rpc, bit v, logic [31:0] pc,
                              logic [31:0] addr, bit flt);
    vec_t t;
    t.rst = rst; t.en = en; t.rdy = rdy; t.rv = rv; t.rpc = rpc;
    t.v = v; t.pc = pc; t.ins = pc; t.addr = addr; t.flt = flt;
    return t;
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  task automatic mem_default();
    for (int i = 0; i < 128; i++)
      mem[i] = 32'(i * 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ent_t        mq[$];
    ent_t        m_last;
    logic [31:0] m_pc;
    bit          m_fault;
    bit          found;
    logic [31:0] cap_ins;

    mem_default();

    // Sequential streaming with ready high.
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,  32'h0,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h0,  32'h4,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h4,  32'h8,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h8,  32'hC,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'hC,  32'h10, 0));
    // Backpressure for five cycles, then drain with no gap.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,  32'h0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0,  32'h4,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0,  32'h8,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0,  32'h8,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0,  32'h8,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h0,  32'h8,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h4,  32'hC,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h8,  32'h10, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'hC,  32'h14, 0));
    // Redirect to 0xB6 with full queue and coincident pop.
    tbl.push_back(mk(1, 1, 0, 0, 0,     0, 32'h0,  32'h0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,     1, 32'h0,  32'h4,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0,     1, 32'h0,  32'h8,  0));
    tbl.push_back(mk(0, 1, 1, 1, 32'hB6, 1, 32'h0, 32'h8,  0));
    tbl.push_back(mk(0, 1, 1, 0, 0,     0, 32'h0,  32'hB4, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,     1, 32'hB4, 32'hB8, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,     1, 32'hB8, 32'hBC, 0));
    // Enable low holds fetch.
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0, 32'h0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1, 32'h0, 32'h4, 0));

    next_cycle();
    foreach (tbl[k]) begin
      if (tbl[k].rst)
        pulse_reset();
      Enable        = tbl[k].en;
      InstrReady    = tbl[k].rdy;
      RedirectValid = tbl[k].rv;
      RedirectPC    = tbl[k].rpc;
      @(negedge Clk);
      chk($sformatf("vec%0d_valid", k), 32'(InstrValid), 32'(tbl[k].v));
      chk($sformatf("vec%0d_pc", k),    InstrPC,         tbl[k].pc);
      chk($sformatf("vec%0d_instr", k), InstrOut,        tbl[k].ins);
      chk($sformatf("vec%0d_addr", k),  ImemAddress,     tbl[k].addr);
      chk($sformatf("vec%0d_fault", k), 32'(Fault),      32'(tbl[k].flt));
      next_cycle();
    end
    RedirectValid = 1'b0;

    // Run off the end of memory, then recover with a redirect.
    pulse_reset();
    Enable = 1'b1;
    InstrReady = 1'b1;
    found = 1'b0;
    cap_ins = '0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge Clk);
      if (InstrValid && InstrPC == 32'h1FC) begin
        found = 1'b1;
        cap_ins = InstrOut;
      end
      next_cycle();
    end
    chk("reach_word127", 32'(found), 32'd1);
    chk("word127_instr", cap_ins, 32'h1FC);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("fault_set", 32'(Fault), 32'd1);
      chk("fault_no_valid", 32'(InstrValid), 32'd0);
      chk("fault_addr_hold", ImemAddress, 32'h200);
      next_cycle();
    end
    RedirectValid = 1'b1;
    RedirectPC = 32'h0;
    next_cycle();
    RedirectValid = 1'b0;
    @(negedge Clk);
    chk("redir_clears_fault", 32'(Fault), 32'd0);
    chk("redir_gap", 32'(InstrValid), 32'd0);
    next_cycle();
    @(negedge Clk);
    chk("resume_valid", 32'(InstrValid), 32'd1);
    chk("resume_pc", InstrPC, 32'h0);
    next_cycle();

    // Async reset in mid-cycle with Fault set and an entry queued.
    InstrReady = 1'b0;
    RedirectValid = 1'b1;
    RedirectPC = 32'h1FC;
    next_cycle();
    RedirectValid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge Clk);
    chk("pre_rst_fault", 32'(Fault), 32'd1);
    chk("pre_rst_valid", 32'(InstrValid), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_valid", 32'(InstrValid), 32'd0);
    chk("arst_instr", InstrOut, 32'h0);
    chk("arst_pc", InstrPC, 32'h0);
    chk("arst_fault", 32'(Fault), 32'd0);
    chk("arst_halted", 32'(Halted), 32'd0);
    chk("arst_addr", ImemAddress, 32'h0);
    next_cycle();
    Reset = 1'b0;
    InstrReady = 1'b1;
    @(negedge Clk);
    chk("post_rst_first_gap", 32'(InstrValid), 32'd0);
    next_cycle();
    @(negedge Clk);
    chk("post_rst_valid", 32'(InstrValid), 32'd1);
    chk("post_rst_pc", InstrPC, 32'h0);
    next_cycle();

    // Self-loop jump at 0xF4.
    mem[61] = 32'h0800_003D;
    pulse_reset();
    Enable = 1'b1;
    InstrReady = 1'b1;
    RedirectValid = 1'b1;
    RedirectPC = 32'hF4;
    next_cycle();
    RedirectValid = 1'b0;
    next_cycle();
    @(negedge Clk);
    chk("loop_valid", 32'(InstrValid), 32'd1);
    chk("loop_pc", InstrPC, 32'hF4);
    chk("loop_instr", InstrOut, 32'h0800_003D);
`ifdef IMEM_FETCH_HALT_DETECT_EN
    chk("loop_halted", 32'(Halted), 32'd1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge Clk);
      chk("halt_no_valid", 32'(InstrValid), 32'd0);
      chk("halt_stays", 32'(Halted), 32'd1);
    end
`else
    chk("loop_not_halted", 32'(Halted), 32'd0);
    next_cycle();
    @(negedge Clk);
    chk("loop_next_valid", 32'(InstrValid), 32'd1);
    chk("loop_next_pc", InstrPC, 32'hF8);
`endif
    next_cycle();
    mem[61] = 32'(61 * 4);

    // Randomized run against the reference model; bit 27 is cleared so no
    // word decodes as a jump.
    for (int i = 0; i < 128; i++)
      mem[i] = $urandom() & 32'hF7FF_FFFF;
    pulse_reset();
    mq.delete();
    m_pc = 32'h0;
    m_fault = 1'b0;
    m_last = '{32'h0, 32'h0};
    for (int c = 0; c < 1500; c++) begin
      ent_t exp_e;
      bit   exp_v;
      bit   pop;
      int   sz;
      Enable        = ($urandom_range(0, 3) != 0);
      InstrReady    = $urandom_range(0, 1) == 1;
      RedirectValid = ($urandom_range(0, 19) == 0);
      RedirectPC    = $urandom_range(0, 32'h21F);
      exp_v = (mq.size() != 0);
      exp_e = exp_v ? mq[0] : m_last;
      @(negedge Clk);
      chk("rnd_valid", 32'(InstrValid), 32'(exp_v));
      chk("rnd_pc", InstrPC, exp_e.pc);
      chk("rnd_instr", InstrOut, exp_e.ins);
      chk("rnd_addr", ImemAddress, m_pc);
      chk("rnd_fault", 32'(Fault), 32'(m_fault));
      if (exp_v)
        m_last = mq[0];
      if (RedirectValid) begin
        mq.delete();
        m_pc = RedirectPC & ~32'd3;
        m_fault = 1'b0;
      end else begin
        sz  = mq.size();
        pop = exp_v && InstrReady;
        if (pop)
          void'(mq.pop_front());
        if (!m_fault && Enable && (sz < 2 || pop)) begin
          if (m_pc >= 32'd512) begin
            m_fault = 1'b1;
          end else begin
            mq.push_back('{m_pc, mem[m_pc[8:2]]});
            m_pc = m_pc + 32'd4;
          end
        end
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
